// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: depth derivation and the per-cycle accept record.
package fifo_pkg;

    function automatic int fifo_depth(input int addr_lines);
        return 1 << addr_lines;
    endfunction

    typedef struct packed {
        logic wr;
        logic rd;
    } fifo_acc_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, contents never reset.
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_LINES = 8,
    parameter int ADDR_LINES = 8
) (
    input  logic                  clk,
    input  logic                  wen,
    input  logic [ADDR_LINES-1:0] waddr,
    input  logic [DATA_LINES-1:0] wdata,
    input  logic [ADDR_LINES-1:0] raddr,
    output logic [DATA_LINES-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ADDR_LINES);

    logic [DATA_LINES-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, live programmable almost flags, sticky errors,
// synchronous flush and a build-time choice of registered or fall-through read.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int DATA_LINES = 8,
    parameter int ADDR_LINES = 8,
    parameter bit FWFT       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic [DATA_LINES-1:0] wdata,
    input  logic                  rinc,
    input  logic                  flush,
    input  logic [ADDR_LINES:0]   afull_thresh,
    input  logic [ADDR_LINES:0]   aempty_thresh,
    output logic [DATA_LINES-1:0] rdata,
    output logic                  rvalid,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_LINES:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                    DEPTH     = fifo_depth(ADDR_LINES);
    localparam logic [ADDR_LINES:0]   DEPTH_CNT = (ADDR_LINES+1)'(DEPTH);
    localparam logic [ADDR_LINES:0]   ONE_CNT   = (ADDR_LINES+1)'(1);
    localparam logic [ADDR_LINES-1:0] ONE_PTR   = ADDR_LINES'(1);

    logic [ADDR_LINES-1:0] wptr;
    logic [ADDR_LINES-1:0] rptr;
    logic [ADDR_LINES:0]   cnt;
    logic [DATA_LINES-1:0] mem_rd;
    fifo_acc_t             acc;

    assign count        = cnt;
    assign wfull        = (cnt == DEPTH_CNT);
    assign rempty       = (cnt == '0);
    assign almost_full  = (cnt >= afull_thresh);
    assign almost_empty = (cnt <= aempty_thresh);

    // Flush swallows both requests so nothing moves and no error is flagged that cycle.
    always_comb begin
        acc    = '0;
        acc.wr = winc && !wfull && !flush;
        acc.rd = rinc && !rempty && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (acc.wr) wptr <= wptr + ONE_PTR;
            if (acc.rd) rptr <= rptr + ONE_PTR;
            case ({acc.wr, acc.rd})
                2'b10:   cnt <= cnt + ONE_CNT;
                2'b01:   cnt <= cnt - ONE_CNT;
                default: cnt <= cnt;
            endcase
            if (winc && wfull)  overflow  <= 1'b1;
            if (rinc && rempty) underflow <= 1'b1;
        end
    end

    sync_fifo_mem #(
        .DATA_LINES (DATA_LINES),
        .ADDR_LINES (ADDR_LINES)
    ) u_mem (
        .clk   (clk),
        .wen   (acc.wr),
        .waddr (wptr),
        .wdata (wdata),
        .raddr (rptr),
        .rdata (mem_rd)
    );

    generate
        if (FWFT) begin : g_fwft
            assign rdata  = mem_rd;
            assign rvalid = !rempty;
        end else begin : g_reg
            logic [DATA_LINES-1:0] rdata_p1;
            logic                  rvalid_p1;

            // p0 -> p1: head word captured on an accepted pop
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_p1  <= '0;
                    rvalid_p1 <= 1'b0;
                end else begin
                    rvalid_p1 <= acc.rd;
                    if (acc.rd) rdata_p1 <= mem_rd;
                end
            end

            assign rdata  = rdata_p1;
            assign rvalid = rvalid_p1;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench: a registered-read and a fall-through instance driven by the same stimulus.
module tb_sync_fifo_prog;

    logic       clk = 1'b0;
    logic       rst, winc, rinc, flush;
    logic [7:0] wdata;
    logic [4:0] aft, aet;

    logic [7:0] rdata0, rdata1;
    logic       rvalid0, wfull0, rempty0, afull0, aempty0, ovf0, udf0;
    logic       rvalid1, wfull1, rempty1, afull1, aempty1, ovf1, udf1;
    logic [4:0] count0, count1;

    int nchk  = 0;
    int npass = 0;

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       r;
        logic [4:0] aft;
        logic [4:0] aet;
        logic [4:0] c;
        logic       e;
        logic       fu;
        logic       af;
        logic       ae;
        logic       rv;
        logic [7:0] rd;
        logic       ov;
        logic       un;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_LINES(8), .ADDR_LINES(4), .FWFT(1'b0)) u_reg (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .flush(flush),
        .afull_thresh(aft), .aempty_thresh(aet),
        .rdata(rdata0), .rvalid(rvalid0), .wfull(wfull0), .rempty(rempty0),
        .almost_full(afull0), .almost_empty(aempty0), .count(count0),
        .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_prog #(.DATA_LINES(8), .ADDR_LINES(4), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .flush(flush),
        .afull_thresh(aft), .aempty_thresh(aet),
        .rdata(rdata1), .rvalid(rvalid1), .wfull(wfull1), .rempty(rempty1),
        .almost_full(afull1), .almost_empty(aempty1), .count(count1),
        .overflow(ovf1), .underflow(udf1)
    );

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s[%0d] got 0x%0h expected 0x%0h", nm, idx, act, exp);
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic f);
        winc  = w;
        wdata = d;
        rinc  = r;
        flush = f;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic w, input logic [7:0] d, input logic r, input logic [4:0] at,
                       input logic [4:0] et, input logic [4:0] c, input logic e, input logic fu,
                       input logic af, input logic ae, input logic rv, input logic [7:0] rd,
                       input logic ov, input logic un);
        vec_t v;
        v.w = w; v.d = d; v.r = r; v.aft = at; v.aet = et; v.c = c; v.e = e; v.fu = fu;
        v.af = af; v.ae = ae; v.rv = rv; v.rd = rd; v.ov = ov; v.un = un;
        tbl.push_back(v);
    endtask

    initial begin
        logic [7:0] model[$];
        logic [7:0] exp_d;

        rst = 1'b1; winc = 1'b0; rinc = 1'b0; flush = 1'b0; wdata = 8'h00;
        aft = 5'd12; aet = 5'd3;

        //   w  d      r  aft aet  cnt e  fu af ae rv rdata  ov un
        add(1, 8'h00, 0, 12, 3,  1, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        add(1, 8'h01, 0, 12, 3,  2, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        add(1, 8'h02, 0, 12, 3,  3, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        add(1, 8'h03, 0, 12, 3,  4, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        add(0, 8'h00, 1, 12, 3,  3, 0, 0, 0, 1, 1, 8'h00, 0, 0);
        add(1, 8'h04, 1, 12, 3,  3, 0, 0, 0, 1, 1, 8'h01, 0, 0);
        add(1, 8'h05, 0, 12, 3,  4, 0, 0, 0, 0, 0, 8'h01, 0, 0);
        add(0, 8'h00, 0, 12, 4,  4, 0, 0, 0, 1, 0, 8'h01, 0, 0);
        add(1, 8'h06, 0, 12, 3,  5, 0, 0, 0, 0, 0, 8'h01, 0, 0);
        add(1, 8'h07, 0, 12, 3,  6, 0, 0, 0, 0, 0, 8'h01, 0, 0);
        add(1, 8'h08, 0, 12, 3,  7, 0, 0, 0, 0, 0, 8'h01, 0, 0);
        add(1, 8'h09, 0, 12, 3,  8, 0, 0, 0, 0, 0, 8'h01, 0, 0);
        add(1, 8'h0A, 0, 12, 3,  9, 0, 0, 0, 0, 0, 8'h01, 0, 0);
        add(1, 8'h0B, 0, 12, 3, 10, 0, 0, 0, 0, 0, 8'h01, 0, 0);
        add(0, 8'h00, 0,  8, 3, 10, 0, 0, 1, 0, 0, 8'h01, 0, 0);
        add(1, 8'h0C, 0, 12, 3, 11, 0, 0, 0, 0, 0, 8'h01, 0, 0);
        add(1, 8'h0D, 0, 12, 3, 12, 0, 0, 1, 0, 0, 8'h01, 0, 0);
        add(1, 8'h0E, 0, 12, 3, 13, 0, 0, 1, 0, 0, 8'h01, 0, 0);
        add(1, 8'h0F, 0, 12, 3, 14, 0, 0, 1, 0, 0, 8'h01, 0, 0);
        add(1, 8'h10, 0, 12, 3, 15, 0, 0, 1, 0, 0, 8'h01, 0, 0);
        add(1, 8'h11, 0, 12, 3, 16, 0, 1, 1, 0, 0, 8'h01, 0, 0);
        add(1, 8'h99, 1, 12, 3, 15, 0, 0, 1, 0, 1, 8'h02, 1, 0);
        add(0, 8'h00, 0, 12, 3, 15, 0, 0, 1, 0, 0, 8'h02, 1, 0);

        // Reset held for two cycles
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_count", 0, count0, 0);
        chk("rst_rempty", 0, rempty0, 1);
        chk("rst_wfull", 0, wfull0, 0);
        chk("rst_aempty", 0, aempty0, 1);
        chk("rst_afull", 0, afull0, 0);
        chk("rst_rvalid", 0, rvalid0, 0);
        chk("rst_rdata", 0, rdata0, 0);
        chk("rst_ovf", 0, ovf0, 0);
        chk("rst_udf", 0, udf0, 0);
        chk("rst_fwft_rvalid", 0, rvalid1, 0);

        // Threshold walk and full-boundary collision
        foreach (tbl[i]) begin
            aft = tbl[i].aft;
            aet = tbl[i].aet;
            step(tbl[i].w, tbl[i].d, tbl[i].r, 1'b0);
            chk("tbl_count", i, count0, tbl[i].c);
            chk("tbl_rempty", i, rempty0, tbl[i].e);
            chk("tbl_wfull", i, wfull0, tbl[i].fu);
            chk("tbl_afull", i, afull0, tbl[i].af);
            chk("tbl_aempty", i, aempty0, tbl[i].ae);
            chk("tbl_rvalid", i, rvalid0, tbl[i].rv);
            chk("tbl_rdata", i, rdata0, tbl[i].rd);
            chk("tbl_ovf", i, ovf0, tbl[i].ov);
            chk("tbl_udf", i, udf0, tbl[i].un);
            chk("tbl_fwft_count", i, count1, tbl[i].c);
        end
        aft = 5'd12; aet = 5'd3;

        // Reset in the middle of operation
        rst = 1'b1;
        step(0, 8'h00, 0, 0);
        rst = 1'b0;
        chk("midrst_count", 0, count0, 0);
        chk("midrst_ovf", 0, ovf0, 0);
        chk("midrst_rvalid", 0, rvalid0, 0);
        chk("midrst_rdata", 0, rdata0, 0);
        chk("midrst_fwft_count", 0, count1, 0);

        // Fill then drain
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i), 0, 0);
            chk("fill_count", i, count0, i + 1);
            chk("fill_wfull", i, wfull0, (i == 15) ? 1 : 0);
        end
        step(1, 8'hEE, 0, 0);
        chk("fill_over_count", 0, count0, 16);
        chk("fill_over_ovf", 0, ovf0, 1);
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00, 1, 0);
            chk("drain_rvalid", i, rvalid0, 1);
            chk("drain_rdata", i, rdata0, i);
            step(0, 8'h00, 0, 0);
            chk("drain_rvalid_off", i, rvalid0, 0);
            chk("drain_rdata_hold", i, rdata0, i);
        end
        chk("drain_rempty", 0, rempty0, 1);

        // Empty with simultaneous write and read
        step(1, 8'h55, 1, 0);
        chk("empty_rw_count", 0, count0, 1);
        chk("empty_rw_udf", 0, udf0, 1);
        chk("empty_rw_rvalid", 0, rvalid0, 0);
        model.push_back(8'h55);

        // Streaming across two pointer wraps
        for (int i = 0; i < 40; i++) begin
            exp_d = model.pop_front();
            model.push_back(8'h80 + 8'(i));
            step(1, 8'h80 + 8'(i), 1, 0);
            chk("wrap_rdata", i, rdata0, exp_d);
            chk("wrap_count", i, count0, 1);
        end

        // Flush at count 7 with a concurrent write
        for (int i = 0; i < 6; i++) step(1, 8'h60 + 8'(i), 0, 0);
        chk("preflush_count", 0, count0, 7);
        chk("preflush_fwft_rvalid", 0, rvalid1, 1);
        step(1, 8'hDD, 0, 1);
        chk("flush_count", 0, count0, 0);
        chk("flush_rempty", 0, rempty0, 1);
        chk("flush_udf", 0, udf0, 0);
        chk("flush_ovf", 0, ovf0, 0);
        chk("flush_fwft_rvalid", 0, rvalid1, 0);
        step(1, 8'h3C, 0, 0);
        chk("postflush_count", 0, count0, 1);
        step(0, 8'h00, 1, 0);
        chk("postflush_rdata", 0, rdata0, 8'h3C);
        chk("postflush_rempty", 0, rempty0, 1);

        // Fall-through read on the FWFT instance
        step(1, 8'hA5, 0, 0);
        chk("fwft_rdata", 0, rdata1, 8'hA5);
        chk("fwft_rvalid", 0, rvalid1, 1);
        chk("fwft_rempty", 0, rempty1, 0);
        step(0, 8'h00, 0, 0);
        chk("fwft_hold_rvalid", 0, rvalid1, 1);
        chk("fwft_hold_rdata", 0, rdata1, 8'hA5);
        step(0, 8'h00, 1, 0);
        chk("fwft_pop_rempty", 0, rempty1, 1);
        chk("fwft_pop_rvalid", 0, rvalid1, 0);
        chk("fwft_reg_rdata", 0, rdata0, 8'hA5);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
